shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencer and requester arbiter for the triplicated universal shift register (`top`). It drives the register's `enable`, `load`, `mode` and `parallel_in` inputs to serialize transmit words (PISO) and to capture received serial words (serial-in, right shift). A transmit requester and a receive requester share the register; round-robin arbitration grants one at a time. The block sits beside `top` and shares its clock and reset.

## Interface
Parameters:
- `WIDTH`, default 4: word width; must match the register width; legal values are WIDTH >= 2.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset (same net as the register's `rst`).
- `tx_valid`  in  1  — transmit word offered.
- `tx_ready`  out  1  — transmit word accepted when `tx_valid & tx_ready`.
- `tx_data`  in  WIDTH  — transmit word.
- `tx_bit_strobe`  out  1  — high while the register's `serial_out` carries a valid transmit bit.
- `rx_start`  in  1  — one-cycle pulse that requests capture of one word.
- `rx_valid`  out  1  — one-cycle pulse; `rx_data` is valid.
- `rx_data`  out  WIDTH  — captured word; holds until the next capture.
- `busy`  out  1  — state is not IDLE.
- `reg_enable`, `reg_load`  out  1 each  — to the register.
- `reg_mode`  out  2  — to the register (00 = serial-in, right shift; 10 = PISO; 11 = PIPO hold).
- `reg_parallel_in`  out  WIDTH  — to the register.
- `reg_parallel_out`  in  WIDTH  — voted `parallel_out` from the register.

## Operation
- States are IDLE, TX_LOAD, TX_SHIFT, RX_SHIFT and RX_DONE. The register-side outputs are Moore outputs, decoded from the state.
- **IDLE** drives enable=0, load=0, mode=11. `tx_ready` = 1 only in IDLE, and only when the arbiter grants tx.
- **rx pending flag.** `rx_start` sets an `rx_pending` flag in any state. The flag clears when RX_SHIFT is entered.
- **Arbitration in IDLE.**
  - If only tx is requesting (`tx_valid`), grant tx.
  - If only rx is requesting (`rx_pending`), grant rx.
  - If both are requesting, grant the requester not served last. After reset, tx is treated as favoured.
  - When rx is granted, `tx_ready` = 0.
- **tx handshake.** On the handshake, `tx_data` is captured into a holding register and the state goes to TX_LOAD.
- **TX_LOAD** drives mode=10, load=1, enable=1, `reg_parallel_in` = held word. Next state is TX_SHIFT with bit count = 0.
- **TX_SHIFT** drives mode=10, load=0, enable=1, `tx_bit_strobe`=1.
  - Bits go out LSB first.
  - The state lasts WIDTH cycles (count 0..WIDTH-1). It then returns to IDLE, leaving the register holding 0.
- **RX_SHIFT** drives mode=00, enable=1.
  - The state lasts WIDTH cycles. `serial_in` is sampled on each edge.
  - The first bit received ends at bit 0 and the last at bit WIDTH-1.
- **RX_DONE** drives enable=0, mode=11.
  - `reg_parallel_out` is captured into `rx_data`, and `rx_valid` is set for one cycle.
  - Next state is IDLE.
- The bit counter is $clog2(WIDTH) bits wide. It wraps to 0 on every state exit.
- `reg_parallel_in` = 0 outside TX_LOAD.

## Timing
- **Reset values:** state IDLE, `tx_ready`=1, `tx_bit_strobe`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, `reg_enable`=0, `reg_load`=0, `reg_mode`=11, `reg_parallel_in`=0, `rx_pending`=0, last-served = rx.
- **tx latency:** handshake in cycle t; load in t+1; bit k on `serial_out` in cycle t+2+k. The block is back in IDLE at t+2+WIDTH, and `tx_ready` may be high again that cycle.
- **rx latency:** RX_SHIFT occupies cycles r..r+WIDTH-1 and RX_DONE is cycle r+WIDTH. `rx_valid`/`rx_data` are registered and are visible in cycle r+WIDTH+1.
- **Back-to-back tx** throughput is one word per WIDTH+2 cycles.
- **Reset asserted mid-operation:** all state aborts immediately to the reset values above. The partial word is discarded and no `rx_valid` is produced.
- `rx_start` pulses while `rx_pending` is already set merge into a single request.

## Structure
- Package `shift_ctrl_pkg` holds:
  - state enum `shift_ctrl_state_t`;
  - mode constants `MODE_SIRS`=2'b00, `MODE_SILS`=2'b01, `MODE_PISO`=2'b10, `MODE_PIPO`=2'b11.
- Sub-module `shift_ctrl_arb` is a 2-requester round-robin arbiter holding the last-served flop. It is updated only on a grant in IDLE.

## Test plan
(WIDTH=4, block connected to `top`.)
- **Single transmit:** `tx_data`=4'b1011 accepted at t → `serial_out`=1,1,0,1 at t+2..t+5 with `tx_bit_strobe` high; `tx_ready`=0 for t+1..t+5; `parallel_out`=0 at t+6.
- **Single receive:** `rx_start` pulse, then `serial_in`=1,0,0,1 (first to last) → `rx_data`=4'b1001 with a one-cycle `rx_valid`; `busy` is low the same cycle.
- **Simultaneous requests after reset:** tx 4'hA and `rx_start` in the same cycle → tx served first, then rx. Repeat with both requesting again → tx served first again (alternation).
- **rx during tx:** `rx_start` pulse during TX_SHIFT → rx is serviced immediately after tx completes; the held tx word is unaffected.
- **Reset mid-TX_SHIFT:** assert `rst` after 2 bits → all outputs at reset values; after release, `tx_ready`=1 and no further strobes.
- **Back-to-back tx:** 4'h5 then 4'hC with `tx_valid` held → second handshake exactly 6 cycles after the first; bit stream 1,0,1,0,0,0,1,1.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
// Holds the FSM state enum, register mode encodings, the arbiter's
// last-served encoding and the register control payload with its
// per-state decode.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_LOAD  = 3'd1,
    ST_TX_SHIFT = 3'd2,
    ST_RX_SHIFT = 3'd3,
    ST_RX_DONE  = 3'd4
  } shift_ctrl_state_t;

  // Universal shift register mode encodings.
  localparam logic [1:0] MODE_SIRS = 2'b00;
  localparam logic [1:0] MODE_SILS = 2'b01;
  localparam logic [1:0] MODE_PISO = 2'b10;
  localparam logic [1:0] MODE_PIPO = 2'b11;

  typedef enum logic {
    SERVED_TX = 1'b0,
    SERVED_RX = 1'b1
  } served_t;

  // Control word presented to the shift register.
  typedef struct packed {
    logic       enable;
    logic       load;
    logic [1:0] mode;
  } reg_ctrl_t;

  // Moore decode of the register controls for a given state.
  function automatic reg_ctrl_t ctrl_for_state(input shift_ctrl_state_t st);
    reg_ctrl_t c;
    c.enable = 1'b0;
    c.load   = 1'b0;
    c.mode   = MODE_PIPO;
    case (st)
      ST_TX_LOAD: begin
        c.enable = 1'b1;
        c.load   = 1'b1;
        c.mode   = MODE_PISO;
      end
      ST_TX_SHIFT: begin
        c.enable = 1'b1;
        c.mode   = MODE_PISO;
      end
      ST_RX_SHIFT: begin
        c.enable = 1'b1;
        c.mode   = MODE_SIRS;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Bundle between the sequencer and its users/the shift register.
//   tx_valid/tx_ready/tx_data : transmit word handshake
//   tx_bit_strobe             : serial_out carries a valid transmit bit
//   rx_start                  : request capture of one word
//   rx_valid/rx_data          : captured word (valid pulse, held data)
//   busy                      : sequencer not idle
//   reg_*                     : shift register control and parallel data
// slave = the sequencer, master = everything around it.
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_bit_strobe;
  logic             rx_start;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             reg_enable;
  logic             reg_load;
  logic [1:0]       reg_mode;
  logic [WIDTH-1:0] reg_parallel_in;
  logic [WIDTH-1:0] reg_parallel_out;

  modport slave (
    input  tx_valid, tx_data, rx_start, reg_parallel_out,
    output tx_ready, tx_bit_strobe, rx_valid, rx_data, busy,
           reg_enable, reg_load, reg_mode, reg_parallel_in
  );

  modport master (
    output tx_valid, tx_data, rx_start, reg_parallel_out,
    input  tx_ready, tx_bit_strobe, rx_valid, rx_data, busy,
           reg_enable, reg_load, reg_mode, reg_parallel_in
  );

endinterface

// File: rtl/shift_ctrl_arb.sv
// Two-requester round-robin arbiter (tx vs rx) for the shift sequencer.
//   clk, rst     : clock, async active-low reset
//   i_idle       : sequencer is idle; grants only exist here
//   i_req_tx     : transmit word offered
//   i_req_rx     : receive request pending
//   o_gnt_tx_c   : tx may proceed (also high with no request at all)
//   o_gnt_rx_c   : rx wins this cycle
module shift_ctrl_arb
  import shift_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_req_tx,
  input  logic i_req_rx,
  output logic o_gnt_tx_c,
  output logic o_gnt_rx_c
);

  served_t r_last;
  logic    w_rx_wins;

  // rx wins when it is alone, or when both request and tx went last.
  assign w_rx_wins  = i_req_rx & (~i_req_tx | (r_last == SERVED_TX));
  assign o_gnt_rx_c = i_idle & w_rx_wins;
  assign o_gnt_tx_c = i_idle & ~w_rx_wins;

  // Last-served moves only when a grant actually starts a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= SERVED_RX;
    end else if (o_gnt_rx_c) begin
      r_last <= SERVED_RX;
    end else if (o_gnt_tx_c && i_req_tx) begin
      r_last <= SERVED_TX;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the universal shift register: serializes transmit words
// (PISO, LSB first) and captures received serial words (right shift),
// with round-robin sharing between the tx and rx requesters.
//   clk, rst : clock, async active-low reset (shared with the register)
//   bus      : slave side of shift_seq_ctrl_if (user handshakes and
//              register controls)
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  shift_ctrl_state_t r_state;
  shift_ctrl_state_t w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  reg_ctrl_t         w_ctrl_nxt;
  logic              w_strobe_nxt;
  logic              w_busy_nxt;

  reg_ctrl_t         r_ctrl;
  logic              r_tx_bit_strobe;
  logic              r_busy;
  logic [WIDTH-1:0]  r_reg_parallel_in;
  logic              r_rx_valid;
  logic [WIDTH-1:0]  r_rx_data;
  logic              r_rx_pending;

  logic              w_idle;
  logic              w_gnt_tx;
  logic              w_gnt_rx;
  logic              w_tx_hs;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_tx_hs = bus.tx_valid & w_gnt_tx;

  shift_ctrl_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_req_tx   (bus.tx_valid),
    .i_req_rx   (r_rx_pending),
    .o_gnt_tx_c (w_gnt_tx),
    .o_gnt_rx_c (w_gnt_rx)
  );

  // State register; register-side outputs are the decode of the next
  // state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_ctrl          <= ctrl_for_state(ST_IDLE);
      r_tx_bit_strobe <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_ctrl          <= w_ctrl_nxt;
      r_tx_bit_strobe <= w_strobe_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  // Next state, bit counter and next-state output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_hs) begin
          w_state_nxt = ST_TX_LOAD;
        end else if (w_gnt_rx) begin
          w_state_nxt = ST_RX_SHIFT;
        end
      end
      ST_TX_LOAD: w_state_nxt = ST_TX_SHIFT;
      ST_TX_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RX_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RX_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RX_DONE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    // Counter restarts from zero on every state exit.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
    w_ctrl_nxt   = ctrl_for_state(w_state_nxt);
    w_strobe_nxt = (w_state_nxt == ST_TX_SHIFT);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
  end

  // Word holding, rx capture and the merged rx request flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_parallel_in <= '0;
      r_rx_valid        <= 1'b0;
      r_rx_data         <= '0;
      r_rx_pending      <= 1'b0;
    end else begin
      // Accepted word is presented only for the TX_LOAD cycle.
      r_reg_parallel_in <= w_tx_hs ? bus.tx_data : '0;
      r_rx_valid        <= (r_state == ST_RX_DONE);
      if (r_state == ST_RX_DONE) begin
        r_rx_data <= bus.reg_parallel_out;
      end
      // A fresh pulse wins over the clear on entry to RX_SHIFT.
      if (bus.rx_start) begin
        r_rx_pending <= 1'b1;
      end else if (w_gnt_rx) begin
        r_rx_pending <= 1'b0;
      end
    end
  end

  assign bus.tx_ready        = w_gnt_tx;
  assign bus.tx_bit_strobe   = r_tx_bit_strobe;
  assign bus.rx_valid        = r_rx_valid;
  assign bus.rx_data         = r_rx_data;
  assign bus.busy            = r_busy;
  assign bus.reg_enable      = r_ctrl.enable;
  assign bus.reg_load        = r_ctrl.load;
  assign bus.reg_mode        = r_ctrl.mode;
  assign bus.reg_parallel_in = r_reg_parallel_in;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a behavioral 4-bit
// universal shift register in place of the triplicated register.
module tb_shift_seq_ctrl;
  import shift_ctrl_pkg::*;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         serial_in;
  logic         serial_out;
  logic [W-1:0] r_q;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register model: 00 right shift in, 01 left shift in, 10 PISO, 11 hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (bus.reg_enable) begin
      case (bus.reg_mode)
        2'b00:   r_q <= {serial_in, r_q[W-1:1]};
        2'b01:   r_q <= {r_q[W-2:0], serial_in};
        2'b10:   r_q <= bus.reg_load ? bus.reg_parallel_in : {1'b0, r_q[W-1:1]};
        default: r_q <= bus.reg_load ? bus.reg_parallel_in : r_q;
      endcase
    end
  end

  assign serial_out           = r_q[0];
  assign bus.reg_parallel_out = r_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check_val({tag, "_strobe"},   32'(bus.tx_bit_strobe), 32'd0);
    check_val({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check_val({tag, "_rx_data"},  32'(bus.rx_data), 32'd0);
    check_val({tag, "_busy"},     32'(bus.busy), 32'd0);
    check_val({tag, "_enable"},   32'(bus.reg_enable), 32'd0);
    check_val({tag, "_load"},     32'(bus.reg_load), 32'd0);
    check_val({tag, "_mode"},     32'(bus.reg_mode), 32'(MODE_PIPO));
    check_val({tag, "_pin"},      32'(bus.reg_parallel_in), 32'd0);
  endtask

  // Offer w in the current (idle) cycle and follow it out bit by bit.
  // rx_at >= 0 pulses rx_start during that bit's cycle.
  // Returns in the first idle cycle after the word.
  task automatic run_tx(input logic [W-1:0] w, input int rx_at, input string tag);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    #1;
    check_val({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_start = 1'b0;
    check_val({tag, "_load"}, 32'({bus.reg_enable, bus.reg_load, bus.reg_mode}), 32'b1110);
    check_val({tag, "_pin"},  32'(bus.reg_parallel_in), 32'(w));
    check_val({tag, "_busy_ready"}, 32'({bus.busy, bus.tx_ready}), 32'b10);
    for (int k = 0; k < int'(W); k++) begin
      step();
      bus.rx_start = (k == rx_at);
      check_val({tag, "_bit"}, 32'({bus.tx_bit_strobe, serial_out}), 32'({1'b1, w[k]}));
      check_val({tag, "_shift_ready"}, 32'(bus.tx_ready), 32'd0);
    end
    step();
    bus.rx_start = 1'b0;
    check_val({tag, "_end_strobe_busy"}, 32'({bus.tx_bit_strobe, bus.busy}), 32'd0);
    check_val({tag, "_end_pout"}, 32'(r_q), 32'd0);
  endtask

  // Called in the first RX_SHIFT cycle; bits are listed first-to-last
  // from the MSB of 'bits'. Returns in the cycle rx_valid is visible.
  task automatic run_rx(input logic [W-1:0] bits, input logic [W-1:0] exp,
                        input bit pulse_rx, input string tag);
    check_val({tag, "_shift_ctrl"}, 32'({bus.busy, bus.reg_enable, bus.reg_mode}), 32'b1100);
    for (int k = 0; k < int'(W); k++) begin
      serial_in    = bits[W-1-k];
      bus.rx_start = pulse_rx && (k == 0);
      step();
    end
    serial_in    = 1'b0;
    bus.rx_start = 1'b0;
    check_val({tag, "_done_ctrl"}, 32'({bus.reg_enable, bus.reg_mode, bus.rx_valid}), 32'b0110);
    step();
    check_val({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check_val({tag, "_data"},  32'(bus.rx_data), 32'(exp));
    check_val({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  int           hs_cyc [2];
  int           n_hs;
  int           n_bits;
  logic [7:0]   stream;

  initial begin
    rst          = 1'b1;
    serial_in    = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_start = 1'b0;
    #2 rst = 1'b0;
    #10;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single transmit of 1011.
    run_tx(4'b1011, -1, "tx1");
    check_val("tx1_ready_again", 32'(bus.tx_ready), 32'd1);

    // Single receive of 1,0,0,1.
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    #1;
    check_val("rx1_pend_ready_busy", 32'({bus.tx_ready, bus.busy}), 32'b00);
    step();
    run_rx(4'b1001, 4'b1001, 1'b0, "rx1");
    step();
    check_val("rx1_valid_drop", 32'(bus.rx_valid), 32'd0);
    check_val("rx1_data_hold",  32'(bus.rx_data), 32'h9);

    // Simultaneous requests straight after reset: tx first.
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.rx_start = 1'b1;
    run_tx(4'hA, -1, "simA");
    bus.tx_valid = 1'b1;
    bus.tx_data  = 4'h6;
    #1;
    check_val("sim_rx_wins", 32'({bus.tx_ready, bus.busy}), 32'b00);
    step();
    run_rx(4'b1100, 4'b0011, 1'b1, "sim_rx");
    check_val("sim_tx_wins", 32'(bus.tx_ready), 32'd1);
    run_tx(4'h6, -1, "sim6");
    check_val("sim_rx2_wins", 32'(bus.tx_ready), 32'd0);
    step();
    run_rx(4'b1011, 4'b1101, 1'b0, "sim_rx2");

    // rx request during TX_SHIFT is served right after the word.
    run_tx(4'b0110, 1, "txrx");
    bus.tx_valid = 1'b1;
    bus.tx_data  = 4'h3;
    #1;
    check_val("txrx_rx_next", 32'(bus.tx_ready), 32'd0);
    step();
    bus.tx_valid = 1'b0;
    run_rx(4'b0001, 4'b1000, 1'b0, "txrx_rx");

    // Reset two bits into a transmit, with an rx request pending.
    bus.tx_data  = 4'hF;
    bus.tx_valid = 1'b1;
    #1;
    step();
    bus.tx_valid = 1'b0;
    step();
    check_val("rst_mid_bit0", 32'(bus.tx_bit_strobe), 32'd1);
    step();
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    step();
    rst = 1'b1;
    check_val("rst_mid_ready", 32'(bus.tx_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      check_val("rst_mid_quiet", 32'({bus.tx_bit_strobe, bus.busy, bus.rx_valid}), 32'd0);
    end

    // Back-to-back words 5 then C with tx_valid held.
    n_hs      = 0;
    n_bits    = 0;
    stream    = '0;
    hs_cyc[0] = 0;
    hs_cyc[1] = 0;
    bus.tx_data  = 4'h5;
    bus.tx_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.tx_bit_strobe) begin
        if (n_bits < 8) stream[n_bits] = serial_out;
        n_bits++;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (n_hs < 2) hs_cyc[n_hs] = c;
        n_hs++;
      end
      step();
      if (n_hs == 1) bus.tx_data = 4'hC;
      if (n_hs >= 2) bus.tx_valid = 1'b0;
    end
    check_val("b2b_hs_count", 32'(n_hs), 32'd2);
    check_val("b2b_hs_gap",   32'(hs_cyc[1] - hs_cyc[0]), 32'd6);
    check_val("b2b_bits",     32'(n_bits), 32'd8);
    check_val("b2b_stream",   32'(stream), 32'hC5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
